// File: rtl/dual_port_memory.sv
// Two-port word memory: port A read-only, port B read/write with byte lanes, each port with credit-gated responses.
// Read latency READ_LATENCY cycles to response; req_ready drops once RESP_DEPTH reads are outstanding on that port.

// Response buffer FIFO: head visible combinationally, pushed entry visible the cycle after the push.
// No flow control of its own; the owner guarantees no push when full and no pop when empty.
module dpm_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_dat;
    end

    assign head_dat = store[rd_ptr];
    assign empty    = (count == '0);
endmodule

// Per-port read return path: LAT-stage data pipeline feeding a fall-through response buffer.
// Latency LAT cycles from acceptance; credits (RESP_DEPTH) guarantee the buffer never overflows.
module dpm_rd_port #(
    parameter int WIDTH = 32,
    parameter int LAT   = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_acc,
    input  logic [WIDTH-1:0] rd_word,
    output logic             req_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_dat
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CREDITS = CW'(DEPTH);

    logic [LAT-1:0]   pipe_vld;
    logic [WIDTH-1:0] pipe_dat [LAT];
    logic [CW-1:0]    outstanding;
    logic             rdy_en;
    logic             consume;
    logic             buf_push;
    logic             buf_pop;
    logic             buf_empty;
    logic [WIDTH-1:0] buf_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= rd_acc;
            for (int i = 1; i < LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rd_acc) pipe_dat[0] <= rd_word;
        for (int i = 1; i < LAT; i++) begin
            if (pipe_vld[i-1]) pipe_dat[i] <= pipe_dat[i-1];
        end
    end

    // Pipeline output bypasses the buffer when it is empty, so an idle port
    // responds exactly LAT cycles after acceptance; otherwise it queues behind.
    assign resp_valid = pipe_vld[LAT-1] | ~buf_empty;
    assign resp_dat   = buf_empty ? pipe_dat[LAT-1] : buf_head;
    assign consume    = resp_valid & resp_ready;
    assign buf_pop    = consume & ~buf_empty;
    assign buf_push   = pipe_vld[LAT-1] & ~(buf_empty & resp_ready);

    dpm_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_resp_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (buf_push),
        .push_dat (pipe_dat[LAT-1]),
        .pop      (buf_pop),
        .head_dat (buf_head),
        .empty    (buf_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            rdy_en      <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(rd_acc) - CW'(consume);
            rdy_en      <= 1'b1;
        end
    end

    assign req_ready = rdy_en & (outstanding < CREDITS);
endmodule

module dual_port_memory #(
    parameter int MEMORY_DEPTH = 32768,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int RESP_DEPTH   = READ_LATENCY + 1,
    localparam int AW          = $clog2(MEMORY_DEPTH),
    localparam int NB          = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic [AW-1:0]         a_address,
    output logic                  a_resp_valid,
    input  logic                  a_resp_ready,
    output logic [DATA_WIDTH-1:0] a_read_data,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic [AW-1:0]         b_address,
    input  logic [NB-1:0]         b_wen,
    input  logic [DATA_WIDTH-1:0] b_write_data,
    output logic                  b_resp_valid,
    input  logic                  b_resp_ready,
    output logic [DATA_WIDTH-1:0] b_read_data
);
    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];
    logic                  a_acc;
    logic                  b_acc;
    logic                  b_rd_acc;
    logic                  b_wr_acc;
    logic [DATA_WIDTH-1:0] a_word;
    logic [DATA_WIDTH-1:0] b_word;

    assign a_acc    = a_req_valid & a_req_ready;
    assign b_acc    = b_req_valid & b_req_ready;
    assign b_wr_acc = b_acc & (|b_wen);
    assign b_rd_acc = b_acc & ~(|b_wen);

    // Both ports sample the array before this edge's write lands: read-first.
    assign a_word = mem[a_address];
    assign b_word = mem[b_address];

    always_ff @(posedge clk) begin
        if (b_wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (b_wen[i]) mem[b_address][8*i +: 8] <= b_write_data[8*i +: 8];
            end
        end
    end

    dpm_rd_port #(
        .WIDTH (DATA_WIDTH),
        .LAT   (READ_LATENCY),
        .DEPTH (RESP_DEPTH)
    ) u_port_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_acc     (a_acc),
        .rd_word    (a_word),
        .req_ready  (a_req_ready),
        .resp_valid (a_resp_valid),
        .resp_ready (a_resp_ready),
        .resp_dat   (a_read_data)
    );

    dpm_rd_port #(
        .WIDTH (DATA_WIDTH),
        .LAT   (READ_LATENCY),
        .DEPTH (RESP_DEPTH)
    ) u_port_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_acc     (b_rd_acc),
        .rd_word    (b_word),
        .req_ready  (b_req_ready),
        .resp_valid (b_resp_valid),
        .resp_ready (b_resp_ready),
        .resp_dat   (b_read_data)
    );
endmodule

// File: doc/dual_port_memory.md
DUAL_PORT_MEMORY -- requirements
Module: dual_port_memory

Interface
REQ-001 Parameter MEMORY_DEPTH, default 32768, number of words; SHALL be a power of two ≥ 2.
REQ-002 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
REQ-003 Parameter READ_LATENCY, default 1, array-to-pipeline-output cycles; SHALL be in range 1..4.
REQ-004 Parameter RESP_DEPTH, default READ_LATENCY+1, response buffer entries per port; SHALL be ≥ READ_LATENCY+1.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 a_req_valid / a_req_ready  in / out  1 / 1  port A (read-only) request handshake.
REQ-008 a_address  in  [0:$clog2(MEMORY_DEPTH)-1]  port A word address.
REQ-009 a_resp_valid / a_resp_ready  out / in  1 / 1  port A response handshake.
REQ-010 a_read_data  out  [0:DATA_WIDTH-1]  port A read data.
REQ-011 b_req_valid / b_req_ready  in / out  1 / 1  port B (read/write) request handshake.
REQ-012 b_address  in  [0:$clog2(MEMORY_DEPTH)-1]  port B word address.
REQ-013 b_wen  in  [0:NB-1]  byte-lane write enables; bit i selects bits [8i +: 8].
REQ-014 b_write_data  in  [0:DATA_WIDTH-1]  port B write data.
REQ-015 b_resp_valid / b_resp_ready  out / in  1 / 1  port B response handshake.
REQ-016 b_read_data  out  [0:DATA_WIDTH-1]  port B read data.

Function
REQ-017 A request SHALL be accepted in a cycle where req_valid && req_ready; address/wen/data are sampled only then.
REQ-018 Port B request with b_wen != 0 SHALL be a write: enabled lanes updated at acceptance edge, disabled lanes unchanged, no response generated.
REQ-019 Port B request with b_wen == 0, and every accepted port A request, SHALL be a read returning exactly one response.
REQ-020 Read data SHALL be available to the response buffer READ_LATENCY cycles after acceptance; with empty buffer and resp_ready high, resp_valid SHALL rise READ_LATENCY cycles after acceptance.
REQ-021 Responses per port SHALL be returned in acceptance order; a response is consumed when resp_valid && resp_ready.
REQ-022 resp_valid SHALL remain high and read_data stable until consumed.
REQ-023 Per port, outstanding count = reads in pipeline + entries in buffer; req_ready SHALL be high iff outstanding < RESP_DEPTH, independent of req_valid (no combinational path from req_valid).
REQ-024 Simultaneous accept and consume on one port SHALL leave outstanding unchanged; req_ready SHALL not drop in that case when previously high.
REQ-025 Port B writes SHALL consume no credit; b_req_ready SHALL gate writes identically to reads.
REQ-026 Same-cycle port A read and port B write to the same address SHALL return the pre-write word on port A (read-first).
REQ-027 Port B read accepted the cycle after a write to the same address SHALL return the written data.
REQ-028 Both ports SHALL operate concurrently at one request per cycle each with full throughput while resp_ready stays high.
REQ-029 Addresses SHALL be full-range; no wrap or out-of-range handling is required beyond MEMORY_DEPTH-1.

Reset
REQ-030 While rst_n is low: a_/b_resp_valid = 0, a_/b_req_ready = 0, outstanding counters = 0, buffers and pipeline valid bits cleared.
REQ-031 req_ready SHALL go high on the first rising clk edge after rst_n deasserts.
REQ-032 Memory array contents SHALL NOT be reset; reset mid-operation SHALL discard in-flight reads without emitting responses, while writes accepted before reset persist.

Verification
REQ-033 Write B addr 0x10 data 0xDEADBEEF wen 1111, then A read 0x10 -> a_read_data 0xDEADBEEF after READ_LATENCY cycles.
REQ-034 Write 0x11223344 to addr 5, then wen 0101 data 0xAABBCCDD -> B read addr 5 returns 0x11BB33DD.
REQ-035 Hold a_resp_ready=0, issue reads every cycle -> exactly RESP_DEPTH accepted, a_req_ready low; release -> data returned in order, no loss or duplication.
REQ-036 Same cycle A read addr 7 (old 0x0) and B write addr 7 0xFFFFFFFF -> A returns 0x0; next A read returns 0xFFFFFFFF.
REQ-037 Assert rst_n low with 3 reads outstanding -> resp_valid 0 immediately; after release no stale responses, prior writes still readable.
REQ-038 Random two-port traffic with random resp_ready, DATA_WIDTH 64, READ_LATENCY 3 -> scoreboard match against reference model, zero mismatches.
